// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU/debug data-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } rd_owner_t;

   localparam int STARVE_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating counter of consecutive cycles the debug requester was denied.
module arb_starve_ctr
   import mem_arb_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       inc,
   input  logic       clr,
   input  logic [7:0] limit,
   output logic [7:0] cnt,
   output logic       at_limit
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q < limit)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt      = cnt_q;
   assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/mem_arbiter.sv
// CPU/debug data-memory arbiter: fixed CPU priority, debug anti-starvation, read-ownership tracking.
// Build option MEM_ARB_DBG_WRITE_EN: when undefined, every debug transfer is forced to a read.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] dbg_rdata,
   output logic [AW-1:0] ma,
   output logic [DW-1:0] mwd,
   output logic          mwr,
   output logic          moe,
   input  logic [DW-1:0] mrd
);

   rd_owner_t  rd_owner_q, rd_owner_d;
   logic [7:0] starve_cnt;
   logic       starve_at_limit;
   logic       dbg_we_eff;
   logic       cnt_unused;

`ifdef MEM_ARB_DBG_WRITE_EN
   assign dbg_we_eff = dbg_we;
   assign mwd        = dbg_gnt ? dbg_wdata : cpu_wdata;
`else
   logic dbg_unused;
   assign dbg_unused = ^{dbg_we, dbg_wdata};
   assign dbg_we_eff = 1'b0;
   assign mwd        = cpu_wdata;
`endif

   arb_starve_ctr u_starve (
      .clock    (clock),
      .reset    (reset),
      .inc      (dbg_req & ~dbg_gnt),
      .clr      (dbg_gnt | ~dbg_req),
      .limit    (8'(STARVE_LIMIT)),
      .cnt      (starve_cnt),
      .at_limit (starve_at_limit)
   );

   // the count itself is only for observation; the grant uses the limit flag
   assign cnt_unused = ^starve_cnt;

   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (!reset) begin
         if (dbg_req && starve_at_limit) begin
            dbg_gnt = 1'b1;
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (dbg_req) begin
            dbg_gnt = 1'b1;
         end
      end
   end

   assign ma  = dbg_gnt ? dbg_addr : cpu_addr;
   assign mwr = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we_eff);
   assign moe = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we_eff);

   always_comb begin
      rd_owner_d = OWN_NONE;
      if (cpu_gnt && !cpu_we) begin
         rd_owner_d = OWN_CPU;
      end else if (dbg_gnt && !dbg_we_eff) begin
         rd_owner_d = OWN_DBG;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_owner_q <= OWN_NONE;
      end else begin
         rd_owner_q <= rd_owner_d;
      end
   end

   // a read granted just before reset must not be reported while reset is high
   assign cpu_rvalid = (rd_owner_q == OWN_CPU) & ~reset;
   assign dbg_rvalid = (rd_owner_q == OWN_DBG) & ~reset;
   assign cpu_rdata  = mrd;
   assign dbg_rdata  = mrd;

endmodule
